hazard_forwarding_unit: RTL and testbench

Pipeline hazard controller for the 5-stage RISC-V core (IF/ID/EX/MEM/WB). It tracks the destination register, write-enable and load flag of the instructions in EX, MEM and WB, using the decode outputs of the control unit. It drives the ALU operand forwarding selects, inserts load-use stalls, and squashes wrong-path instructions on taken branches and jumps. It also counts stall and flush cycles for performance analysis.

---
 rtl/hazard_forwarding_unit.sv | 110 +++++++++++
 tb/tb_hazard_forwarding_unit.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_forwarding_unit.sv
// Hazard controller for the 5-stage core: operand forwarding selects, load-use
// stalls, taken-redirect squash, and saturating stall/flush cycle counters.
module hazard_forwarding_unit #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       ID_rs1,
  input  logic [4:0]       ID_rs2,
  input  logic [4:0]       ID_rd,
  input  logic             ID_use_rs1,
  input  logic             ID_use_rs2,
  input  logic             ID_RF_enable,
  input  logic             ID_load_Instr,
  input  logic             EX_branch_taken,
  output logic             PC_hold,
  output logic             IF_ID_hold,
  output logic             IF_ID_flush,
  output logic             ID_EX_bubble,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int unsigned RegW = 5;

  typedef struct packed {
    logic            valid;
    logic [RegW-1:0] rd;
    logic            we;
    logic            load;
  } stage_rec_t;

  stage_rec_t       ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;
  logic             redirect;
  logic             load_use;

  // x0 is hardwired, so a record targeting it never produces a value to forward.
  function automatic logic is_writing(input stage_rec_t r);
    return r.valid && r.we && (r.rd != RegW'(0));
  endfunction

  function automatic logic [1:0] fwd_sel(input logic use_x, input logic [RegW-1:0] rs,
                                         input stage_rec_t ex, input stage_rec_t mem,
                                         input stage_rec_t wb);
    logic [1:0] sel;
    sel = 2'b00;
    if (use_x) begin
      if (is_writing(ex) && ex.rd == rs)        sel = 2'b01;
      else if (is_writing(mem) && mem.rd == rs) sel = 2'b10;
      else if (is_writing(wb) && wb.rd == rs)   sel = 2'b11;
    end
    return sel;
  endfunction

  always_comb begin
    redirect = rst_n && EX_branch_taken;
    load_use = rst_n && is_writing(ex_q) && ex_q.load &&
               ((ID_use_rs1 && ID_rs1 == ex_q.rd) || (ID_use_rs2 && ID_rs2 == ex_q.rd));

    // A redirect squashes the dependent instruction, so it overrides the stall.
    PC_hold      = load_use && !redirect;
    IF_ID_hold   = load_use && !redirect;
    IF_ID_flush  = redirect;
    ID_EX_bubble = redirect || load_use;

    fwd_a = rst_n ? fwd_sel(ID_use_rs1, ID_rs1, ex_q, mem_q, wb_q) : 2'b00;
    fwd_b = rst_n ? fwd_sel(ID_use_rs2, ID_rs2, ex_q, mem_q, wb_q) : 2'b00;

    ex_d = '0;
    if (!ID_EX_bubble) begin
      ex_d.valid = 1'b1;
      ex_d.rd    = ID_rd;
      ex_d.we    = ID_RF_enable;
      ex_d.load  = ID_load_Instr;
    end
    mem_d = ex_q;
    wb_d  = mem_q;

    stall_count_d = stall_count_q;
    if (PC_hold && stall_count_q != {CNT_W{1'b1}})
      stall_count_d = stall_count_q + CNT_W'(1);
    flush_count_d = flush_count_q;
    if (redirect && flush_count_q != {CNT_W{1'b1}})
      flush_count_d = flush_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q          <= '0;
      mem_q         <= '0;
      wb_q          <= '0;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      ex_q          <= ex_d;
      mem_q         <= mem_d;
      wb_q          <= wb_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;

endmodule

// File: tb/tb_hazard_forwarding_unit.sv
// Directed self-checking bench for hazard_forwarding_unit (CNT_W = 4).
module tb_hazard_forwarding_unit;

  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [4:0]       ID_rs1, ID_rs2, ID_rd;
  logic             ID_use_rs1, ID_use_rs2, ID_RF_enable, ID_load_Instr, EX_branch_taken;
  logic             PC_hold, IF_ID_hold, IF_ID_flush, ID_EX_bubble;
  logic [1:0]       fwd_a, fwd_b;
  logic [CNT_W-1:0] stall_count, flush_count;
  logic [7:0]       ctl;
  int               n_checks = 0;
  int               n_errors = 0;

  hazard_forwarding_unit #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_rd(ID_rd),
    .ID_use_rs1(ID_use_rs1), .ID_use_rs2(ID_use_rs2),
    .ID_RF_enable(ID_RF_enable), .ID_load_Instr(ID_load_Instr),
    .EX_branch_taken(EX_branch_taken),
    .PC_hold(PC_hold), .IF_ID_hold(IF_ID_hold), .IF_ID_flush(IF_ID_flush),
    .ID_EX_bubble(ID_EX_bubble), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  // Packed view: {PC_hold, IF_ID_hold, IF_ID_flush, ID_EX_bubble, fwd_a, fwd_b}
  assign ctl = {PC_hold, IF_ID_hold, IF_ID_flush, ID_EX_bubble, fwd_a, fwd_b};

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic u1, input logic u2, input logic we, input logic ld,
                       input logic br);
    ID_rs1 = rs1; ID_rs2 = rs2; ID_rd = rd;
    ID_use_rs1 = u1; ID_use_rs2 = u2; ID_RF_enable = we; ID_load_Instr = ld;
    EX_branch_taken = br;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush_pipe();
    for (int i = 0; i < 3; i++) begin
      drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (ctl !== 8'b0000_0000) begin
        n_errors++; $display("FAIL reset_ctl[%0d] got %b exp %b", i, ctl, 8'b0);
      end
      n_checks++;
      if ({stall_count, flush_count} !== 8'h00) begin
        n_errors++;
        $display("FAIL reset_cnt[%0d] got stall=%0d flush=%0d exp 0/0", i, stall_count, flush_count);
      end
    end
    rst_n = 1'b1;
    drive(5'd5, 5'd5, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (ctl !== 8'b0000_0000) begin
      n_errors++; $display("FAIL post_reset got %b exp %b", ctl, 8'b0);
    end
    tick();
  endtask

  task automatic test_alu_chain();
    flush_pipe();
    drive(5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    drive(5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (ctl !== 8'b0000_0100) begin
      n_errors++; $display("FAIL alu_dist1 got %b exp %b", ctl, 8'b0000_0100);
    end
    tick();
    drive(5'd0, 5'd5, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (ctl !== 8'b0000_0010) begin
      n_errors++; $display("FAIL alu_dist2 got %b exp %b", ctl, 8'b0000_0010);
    end
    tick();
    drive(5'd5, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (ctl !== 8'b0000_1100) begin
      n_errors++; $display("FAIL alu_dist3 got %b exp %b", ctl, 8'b0000_1100);
    end
    tick();
    n_checks++;
    if (ctl !== 8'b0000_0000) begin
      n_errors++; $display("FAIL alu_dist4 got %b exp %b", ctl, 8'b0);
    end
    // Two back-to-back writers of x5: nearest producer wins.
    flush_pipe();
    drive(5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    drive(5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    drive(5'd5, 5'd5, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (ctl !== 8'b0000_0101) begin
      n_errors++; $display("FAIL prio_ex_mem got %b exp %b", ctl, 8'b0000_0101);
    end
    tick();
    n_checks++;
    if (ctl !== 8'b0000_1010) begin
      n_errors++; $display("FAIL prio_mem_wb got %b exp %b", ctl, 8'b0000_1010);
    end
    tick();
  endtask

  task automatic test_x0();
    flush_pipe();
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    drive(5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (ctl !== 8'b0000_0000) begin
      n_errors++; $display("FAIL x0_no_hazard got %b exp %b", ctl, 8'b0);
    end
    tick();
  endtask

  task automatic test_load_use();
    flush_pipe();
    drive(5'd0, 5'd0, 5'd7, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    drive(5'd3, 5'd7, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (ctl !== 8'b1101_0001) begin
      n_errors++; $display("FAIL load_use_stall got %b exp %b", ctl, 8'b1101_0001);
    end
    tick();
    n_checks++;
    if (ctl !== 8'b0000_0010) begin
      n_errors++; $display("FAIL load_use_release got %b exp %b", ctl, 8'b0000_0010);
    end
    n_checks++;
    if (stall_count !== 4'd1) begin
      n_errors++; $display("FAIL load_use_count got %0d exp %0d", stall_count, 1);
    end
    tick();
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    n_checks++;
    if (stall_count !== 4'd1) begin
      n_errors++; $display("FAIL stall_count_stable got %0d exp %0d", stall_count, 1);
    end
  endtask

  task automatic test_simultaneous();
    flush_pipe();
    drive(5'd0, 5'd0, 5'd7, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    drive(5'd7, 5'd0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    n_checks++;
    if (ctl !== 8'b0011_0100) begin
      n_errors++; $display("FAIL simul_ctl got %b exp %b", ctl, 8'b0011_0100);
    end
    tick();
    n_checks++;
    if ({stall_count, flush_count} !== {4'd1, 4'd1}) begin
      n_errors++;
      $display("FAIL simul_cnt got stall=%0d flush=%0d exp 1/1", stall_count, flush_count);
    end
    drive(5'd7, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (ctl !== 8'b0000_1000) begin
      n_errors++; $display("FAIL simul_after got %b exp %b", ctl, 8'b0000_1000);
    end
    tick();
  endtask

  task automatic test_redirect();
    flush_pipe();
    drive(5'd0, 5'd0, 5'd9, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    n_checks++;
    if (ctl !== 8'b0011_0000) begin
      n_errors++; $display("FAIL redirect_ctl got %b exp %b", ctl, 8'b0011_0000);
    end
    tick();
    drive(5'd9, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (ctl !== 8'b0000_0000) begin
      n_errors++; $display("FAIL redirect_squash got %b exp %b", ctl, 8'b0);
    end
    n_checks++;
    if (flush_count !== 4'd2) begin
      n_errors++; $display("FAIL redirect_count got %0d exp %0d", flush_count, 2);
    end
    tick();
  endtask

  task automatic test_reset_mid_stall();
    flush_pipe();
    drive(5'd0, 5'd0, 5'd7, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    rst_n = 1'b0;
    drive(5'd0, 5'd7, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (ctl !== 8'b0000_0000) begin
      n_errors++; $display("FAIL mid_reset_ctl got %b exp %b", ctl, 8'b0);
    end
    tick();
    n_checks++;
    if ({stall_count, flush_count} !== 8'h00) begin
      n_errors++;
      $display("FAIL mid_reset_cnt got stall=%0d flush=%0d exp 0/0", stall_count, flush_count);
    end
    rst_n = 1'b1;
    drive(5'd0, 5'd7, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (ctl !== 8'b0000_0000) begin
      n_errors++; $display("FAIL mid_reset_after got %b exp %b", ctl, 8'b0);
    end
    tick();
  endtask

  task automatic test_saturation();
    logic [CNT_W-1:0] exp_flush;
    exp_flush = '0;
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (exp_flush != 4'd15) exp_flush = exp_flush + 4'd1;
      n_checks++;
      if (flush_count !== exp_flush) begin
        n_errors++; $display("FAIL sat_flush[%0d] got %0d exp %0d", i, flush_count, exp_flush);
      end
    end
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    n_checks++;
    if ({stall_count, flush_count} !== {4'd0, 4'd15}) begin
      n_errors++;
      $display("FAIL sat_hold got stall=%0d flush=%0d exp 0/15", stall_count, flush_count);
    end
  endtask

  initial begin
    test_reset();
    test_alu_chain();
    test_x0();
    test_load_use();
    test_simultaneous();
    test_redirect();
    test_reset_mid_stall();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
